ex_pipe_ctrl: RTL and testbench
===============================

// Module: ex_pipe_ctrl
// PURPOSE
//  Pipeline sequencer for the EX stage and the PC-redirect path.
//  - Turns the EX jump/JALR redirect into a registered PC update plus timed IF/ID and ID/EX flushes.
//  - Detects load-use hazards between ID and ID/EX and inserts bubbles.
//  - Holds the pipeline while a multi-cycle EX unit (mul/div) runs, with a watchdog timeout.
// PARAMETERS
//  FLUSH_CYCLES    1    cycles spent in REDIRECT after the trigger cycle (>=1)
//  LOAD_USE_CYCLES 1    bubbles inserted per load-use hazard (>=1)
//  MC_TIMEOUT      64   max MC_WAIT cycles before forced exit (>=2)
//  CNT_W           32   width of stall_cnt
// PORTS
//  clk              in   1      rising-edge clock
//  rst_n            in   1      synchronous active-low reset
//  id_ex_valid      in   1      ID/EX holds a real instruction (not a bubble)
//  ex_pc_pc_wen     in   1      EX requests a PC redirect (jump/JALR)
//  ex_pc_pc_data    in   32     EX redirect target
//  id_rs1_addr      in   5      ID source 1 register
//  id_rs1_ren       in   1      ID reads rs1
//  id_rs2_addr      in   5      ID source 2 register
//  id_rs2_ren       in   1      ID reads rs2
//  id_ex_rd_addr    in   5      ID/EX destination register
//  id_ex_rd_wen     in   1      ID/EX writes rd
//  id_ex_is_load    in   1      ID/EX instruction is a load
//  id_ex_is_mc      in   1      ID/EX instruction needs the multi-cycle unit
//  mc_done          in   1      multi-cycle unit result valid (1-cycle pulse)
//  pc_stall         out  1      hold PC
//  if_id_stall      out  1      hold IF/ID register
//  if_id_flush      out  1      load bubble into IF/ID
//  id_ex_stall      out  1      hold ID/EX register
//  id_ex_flush      out  1      load bubble into ID/EX
//  pc_redirect_wen  out  1      registered PC write enable
//  pc_redirect_data out  32     registered PC write value
//  mc_start         out  1      start pulse to the multi-cycle unit
//  mc_timeout       out  1      1-cycle pulse on watchdog expiry
//  stall_cnt        out  CNT_W  count of cycles with pc_stall=1; wraps
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state=RUN; all counters 0; every output 0, including stall_cnt and pc_redirect_data.
//  Any state is abandoned on reset, including mid-REDIRECT and mid-MC_WAIT.
//  FSM states: RUN, REDIRECT, LD_WAIT, MC_WAIT. Priority in RUN: redirect > mc > load-use.
//  Redirect trigger (RUN, id_ex_valid & ex_pc_pc_wen), cycle T:
//  - if_id_flush=id_ex_flush=1 combinationally in T.
//  - Latch target; go to REDIRECT.
//  REDIRECT, entry cycle T+1:
//  - pc_redirect_wen=1 for one cycle only, pc_redirect_data=latched target.
//  - if_id_flush=id_ex_flush=1 in every REDIRECT cycle.
//  - ex_pc_pc_wen is ignored.
//  - Return to RUN after FLUSH_CYCLES cycles.
//  Load-use hazard, when all hold:
//  - id_ex_valid & id_ex_is_load & id_ex_rd_wen & id_ex_rd_addr!=0;
//  - (id_rs1_ren & rs1==rd) | (id_rs2_ren & rs2==rd).
//  - Action: pc_stall=if_id_stall=id_ex_flush=1 in the detect cycle.
//  - LOAD_USE_CYCLES>1: go to LD_WAIT and keep the same outputs for LOAD_USE_CYCLES-1 more cycles, then RUN.
//  - LOAD_USE_CYCLES=1: stay in RUN.
//  Multi-cycle op (RUN, id_ex_valid & id_ex_is_mc, no redirect):
//  - mc_start=1 for one cycle; go to MC_WAIT.
//  - MC_WAIT asserts pc_stall=if_id_stall=id_ex_stall=1, including the start cycle.
//  - mc_done in MC_WAIT: release stalls in that cycle; go to RUN.
//  - Watchdog: counts MC_WAIT cycles. At MC_TIMEOUT, mc_timeout=1 for one cycle, id_ex_flush=1, go to RUN.
//  - mc_done in RUN is ignored.
//  Conflicts in RUN:
//  - redirect + load-use: redirect only, no stall.
//  - redirect + is_mc: redirect only, no mc_start.
//  Stall/flush rules:
//  - id_ex_stall and id_ex_flush are never both 1.
//  - if_id_flush dominates if_id_stall when both would be set.
//  - stall_cnt increments by 1 on every edge where pc_stall=1; wraps at 2^CNT_W.
// STRUCTURE
//  - define.v: state encodings (S_RUN, S_REDIRECT, S_LD_WAIT, S_MC_WAIT).
//  - Sub-module ld_use_detect: combinational rd/rs comparator with rd!=0 qualification, outputs hazard.
//  - Counters and FSM stay in ex_pipe_ctrl.
// TESTING
//  1. JAL, target 0x0000_0100, in RUN, T:
//     - flushes in T and T+1.
//     - pc_redirect_wen=1 with data 0x100 at T+1 only.
//     - RUN at T+2.
//  2. lw x5 in ID/EX, add x6,x5,x1 in ID:
//     - 1 cycle of pc_stall/if_id_stall/id_ex_flush; stall_cnt 0->1.
//     - x0 destination: no stall.
//  3. is_mc, mc_done 5 cycles later:
//     - mc_start pulse; stalls for 5 cycles, released on mc_done.
//     - stall_cnt advances by 5.
//  4. is_mc, no mc_done, MC_TIMEOUT=8:
//     - mc_timeout pulse after 8 cycles with id_ex_flush=1; back to RUN.
//  5. Redirect and load-use in the same cycle:
//     - redirect sequence only, pc_stall=0.
//     - rst_n=0 during REDIRECT: all outputs 0 on the next cycle, state RUN.

Source files
------------

// File: rtl/ex_pipe_ctrl_pkg.sv
// rtl/ex_pipe_ctrl_pkg.sv - shared types for the EX-stage pipeline sequencer
package ex_pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_REDIRECT = 2'd1,
        S_LD_WAIT  = 2'd2,
        S_MC_WAIT  = 2'd3
    } state_t;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic mc_start;
        logic mc_timeout;
    } ctrl_t;

    // One spare bit so a counter can always hold n-1 even when n is 1.
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/ld_use_detect.sv
// rtl/ld_use_detect.sv - load-use hazard comparator between ID and ID/EX
module ld_use_detect (
    input  logic       valid,
    input  logic       is_load,
    input  logic       rd_wen,
    input  logic [4:0] rd_addr,
    input  logic [4:0] rs1_addr,
    input  logic       rs1_ren,
    input  logic [4:0] rs2_addr,
    input  logic       rs2_ren,
    output logic       hazard
);

    logic producer;
    logic rs1_hit;
    logic rs2_hit;

    // x0 never carries a value, so a load targeting it cannot create a dependency.
    assign producer = valid & is_load & rd_wen & (rd_addr != 5'd0);
    assign rs1_hit  = rs1_ren & (rs1_addr == rd_addr);
    assign rs2_hit  = rs2_ren & (rs2_addr == rd_addr);
    assign hazard   = producer & (rs1_hit | rs2_hit);

endmodule

// File: rtl/ex_pipe_ctrl.sv
// rtl/ex_pipe_ctrl.sv - EX-stage pipeline sequencer: PC redirect, load-use bubbles, multi-cycle hold
module ex_pipe_ctrl
    import ex_pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES    = 1,
    parameter int LOAD_USE_CYCLES = 1,
    parameter int MC_TIMEOUT      = 64,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_ex_valid,
    input  logic             ex_pc_pc_wen,
    input  logic [31:0]      ex_pc_pc_data,
    input  logic [4:0]       id_rs1_addr,
    input  logic             id_rs1_ren,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_rs2_ren,
    input  logic [4:0]       id_ex_rd_addr,
    input  logic             id_ex_rd_wen,
    input  logic             id_ex_is_load,
    input  logic             id_ex_is_mc,
    input  logic             mc_done,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             pc_redirect_wen,
    output logic [31:0]      pc_redirect_data,
    output logic             mc_start,
    output logic             mc_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int RD_W = cnt_w(FLUSH_CYCLES);
    localparam int LU_W = cnt_w(LOAD_USE_CYCLES);
    localparam int WD_W = cnt_w(MC_TIMEOUT);
    localparam int LU_LAST_I = (LOAD_USE_CYCLES > 1) ? LOAD_USE_CYCLES - 2 : 0;

    localparam logic [RD_W-1:0] RD_LAST = RD_W'(FLUSH_CYCLES - 1);
    localparam logic [LU_W-1:0] LU_LAST = LU_W'(LU_LAST_I);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MC_TIMEOUT - 1);

    state_t          state;
    state_t          state_nxt;
    ctrl_t           ctrl;
    logic [RD_W-1:0] rd_cnt;
    logic [LU_W-1:0] lu_cnt;
    logic [WD_W-1:0] wd_cnt;
    logic            hazard;
    logic            redirect_take;
    logic            mc_take;
    logic            wd_expire;

    ld_use_detect u_ld_use_detect (
        .valid    (id_ex_valid),
        .is_load  (id_ex_is_load),
        .rd_wen   (id_ex_rd_wen),
        .rd_addr  (id_ex_rd_addr),
        .rs1_addr (id_rs1_addr),
        .rs1_ren  (id_rs1_ren),
        .rs2_addr (id_rs2_addr),
        .rs2_ren  (id_rs2_ren),
        .hazard   (hazard)
    );

    // Redirect outranks the multi-cycle start, which outranks a load-use bubble.
    assign redirect_take = (state == S_RUN) & id_ex_valid & ex_pc_pc_wen;
    assign mc_take       = (state == S_RUN) & id_ex_valid & id_ex_is_mc & ~ex_pc_pc_wen;
    assign wd_expire     = (state == S_MC_WAIT) & ~mc_done & (wd_cnt == WD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_RUN;
            rd_cnt           <= '0;
            lu_cnt           <= '0;
            wd_cnt           <= '0;
            pc_redirect_wen  <= 1'b0;
            pc_redirect_data <= '0;
            stall_cnt        <= '0;
        end else begin
            state           <= state_nxt;
            pc_redirect_wen <= redirect_take;
            if (redirect_take) begin
                pc_redirect_data <= ex_pc_pc_data;
            end
            // Each counter runs only in its own state and is parked at zero otherwise.
            rd_cnt <= (state == S_REDIRECT) ? rd_cnt + RD_W'(1) : '0;
            lu_cnt <= (state == S_LD_WAIT)  ? lu_cnt + LU_W'(1) : '0;
            wd_cnt <= (state == S_MC_WAIT)  ? wd_cnt + WD_W'(1) : '0;
            if (ctrl.pc_stall) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                if (redirect_take) begin
                    state_nxt = S_REDIRECT;
                end else if (mc_take) begin
                    state_nxt = S_MC_WAIT;
                end else if (hazard && (LOAD_USE_CYCLES > 1)) begin
                    state_nxt = S_LD_WAIT;
                end
            end
            S_REDIRECT: begin
                if (rd_cnt == RD_LAST) begin
                    state_nxt = S_RUN;
                end
            end
            S_LD_WAIT: begin
                if (lu_cnt == LU_LAST) begin
                    state_nxt = S_RUN;
                end
            end
            S_MC_WAIT: begin
                if (mc_done || wd_expire) begin
                    state_nxt = S_RUN;
                end
            end
            default: state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        ctrl = '0;
        if (rst_n) begin
            case (state)
                S_RUN: begin
                    if (redirect_take) begin
                        ctrl.if_id_flush = 1'b1;
                        ctrl.id_ex_flush = 1'b1;
                    end else if (mc_take) begin
                        ctrl.mc_start    = 1'b1;
                        ctrl.pc_stall    = 1'b1;
                        ctrl.if_id_stall = 1'b1;
                        ctrl.id_ex_stall = 1'b1;
                    end else if (hazard) begin
                        ctrl.pc_stall    = 1'b1;
                        ctrl.if_id_stall = 1'b1;
                        ctrl.id_ex_flush = 1'b1;
                    end
                end
                S_REDIRECT: begin
                    ctrl.if_id_flush = 1'b1;
                    ctrl.id_ex_flush = 1'b1;
                end
                S_LD_WAIT: begin
                    ctrl.pc_stall    = 1'b1;
                    ctrl.if_id_stall = 1'b1;
                    ctrl.id_ex_flush = 1'b1;
                end
                S_MC_WAIT: begin
                    if (wd_expire) begin
                        ctrl.mc_timeout  = 1'b1;
                        ctrl.id_ex_flush = 1'b1;
                    end else if (!mc_done) begin
                        ctrl.pc_stall    = 1'b1;
                        ctrl.if_id_stall = 1'b1;
                        ctrl.id_ex_stall = 1'b1;
                    end
                end
                default: ctrl = '0;
            endcase
            // A flush always wins over a hold of the same register.
            if (ctrl.if_id_flush) begin
                ctrl.if_id_stall = 1'b0;
            end
            if (ctrl.id_ex_flush) begin
                ctrl.id_ex_stall = 1'b0;
            end
        end
    end

    assign pc_stall    = ctrl.pc_stall;
    assign if_id_stall = ctrl.if_id_stall;
    assign if_id_flush = ctrl.if_id_flush;
    assign id_ex_stall = ctrl.id_ex_stall;
    assign id_ex_flush = ctrl.id_ex_flush;
    assign mc_start    = ctrl.mc_start;
    assign mc_timeout  = ctrl.mc_timeout;

endmodule

// File: tb/tb_ex_pipe_ctrl.sv
// tb/tb_ex_pipe_ctrl.sv - testbench for ex_pipe_ctrl
module tb_ex_pipe_ctrl;

    localparam int FLUSH = 1;
    localparam int LU    = 1;
    localparam int MCT   = 8;
    localparam int CW    = 32;

    localparam logic [6:0] C_PC   = 7'b1000000;
    localparam logic [6:0] C_IFS  = 7'b0100000;
    localparam logic [6:0] C_IFF  = 7'b0010000;
    localparam logic [6:0] C_IDS  = 7'b0001000;
    localparam logic [6:0] C_IDF  = 7'b0000100;
    localparam logic [6:0] C_MS   = 7'b0000010;
    localparam logic [6:0] C_MT   = 7'b0000001;
    localparam logic [6:0] FLUSH2 = C_IFF | C_IDF;
    localparam logic [6:0] LUSE   = C_PC | C_IFS | C_IDF;
    localparam logic [6:0] MCST   = C_PC | C_IFS | C_IDS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_ex_valid;
    logic          ex_pc_pc_wen;
    logic [31:0]   ex_pc_pc_data;
    logic [4:0]    id_rs1_addr;
    logic          id_rs1_ren;
    logic [4:0]    id_rs2_addr;
    logic          id_rs2_ren;
    logic [4:0]    id_ex_rd_addr;
    logic          id_ex_rd_wen;
    logic          id_ex_is_load;
    logic          id_ex_is_mc;
    logic          mc_done;
    logic          pc_stall;
    logic          if_id_stall;
    logic          if_id_flush;
    logic          id_ex_stall;
    logic          id_ex_flush;
    logic          pc_redirect_wen;
    logic [31:0]   pc_redirect_data;
    logic          mc_start;
    logic          mc_timeout;
    logic [CW-1:0] stall_cnt;
    logic [6:0]    ctl;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   exp_cnt;

    always #5 clk = ~clk;

    assign ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, mc_start, mc_timeout};

    ex_pipe_ctrl #(
        .FLUSH_CYCLES    (FLUSH),
        .LOAD_USE_CYCLES (LU),
        .MC_TIMEOUT      (MCT),
        .CNT_W           (CW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_ex_valid      (id_ex_valid),
        .ex_pc_pc_wen     (ex_pc_pc_wen),
        .ex_pc_pc_data    (ex_pc_pc_data),
        .id_rs1_addr      (id_rs1_addr),
        .id_rs1_ren       (id_rs1_ren),
        .id_rs2_addr      (id_rs2_addr),
        .id_rs2_ren       (id_rs2_ren),
        .id_ex_rd_addr    (id_ex_rd_addr),
        .id_ex_rd_wen     (id_ex_rd_wen),
        .id_ex_is_load    (id_ex_is_load),
        .id_ex_is_mc      (id_ex_is_mc),
        .mc_done          (mc_done),
        .pc_stall         (pc_stall),
        .if_id_stall      (if_id_stall),
        .if_id_flush      (if_id_flush),
        .id_ex_stall      (id_ex_stall),
        .id_ex_flush      (id_ex_flush),
        .pc_redirect_wen  (pc_redirect_wen),
        .pc_redirect_data (pc_redirect_data),
        .mc_start         (mc_start),
        .mc_timeout       (mc_timeout),
        .stall_cnt        (stall_cnt)
    );

    task automatic idle();
        id_ex_valid   = 1'b0;
        ex_pc_pc_wen  = 1'b0;
        ex_pc_pc_data = '0;
        id_rs1_addr   = '0;
        id_rs1_ren    = 1'b0;
        id_rs2_addr   = '0;
        id_rs2_ren    = 1'b0;
        id_ex_rd_addr = '0;
        id_ex_rd_wen  = 1'b0;
        id_ex_is_load = 1'b0;
        id_ex_is_mc   = 1'b0;
        mc_done       = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        id_ex_valid   = 1'b1;
        id_ex_is_load = 1'b1;
        id_ex_rd_wen  = 1'b1;
        id_ex_rd_addr = rd;
        id_rs1_addr   = rs1;
        id_rs1_ren    = 1'b1;
        id_rs2_addr   = rs2;
        id_rs2_ren    = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (ctl !== 7'b0) begin errors++; $display("FAIL reset_ctl got %b exp 0", ctl); end
        checks++; if (pc_redirect_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %b exp 0", pc_redirect_wen); end
        checks++; if (pc_redirect_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", pc_redirect_data); end
        checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", stall_cnt); end
        rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_jal();
        @(negedge clk); idle(); id_ex_valid = 1'b1; ex_pc_pc_wen = 1'b1; ex_pc_pc_data = 32'h0000_0100; #1;
        checks++; if (ctl !== FLUSH2) begin errors++; $display("FAIL jal_t_flush got %b exp %b", ctl, FLUSH2); end
        checks++; if (pc_redirect_wen !== 1'b0) begin errors++; $display("FAIL jal_t_wen got %b exp 0", pc_redirect_wen); end
        @(negedge clk); ex_pc_pc_data = 32'h0000_0999; #1;
        checks++; if (ctl !== FLUSH2) begin errors++; $display("FAIL jal_t1_flush got %b exp %b", ctl, FLUSH2); end
        checks++; if (pc_redirect_wen !== 1'b1) begin errors++; $display("FAIL jal_t1_wen got %b exp 1", pc_redirect_wen); end
        checks++; if (pc_redirect_data !== 32'h100) begin errors++; $display("FAIL jal_t1_data got %h exp 100", pc_redirect_data); end
        @(negedge clk); idle(); #1;
        checks++; if (ctl !== 7'b0) begin errors++; $display("FAIL jal_t2_ctl got %b exp 0", ctl); end
        checks++; if (pc_redirect_wen !== 1'b0) begin errors++; $display("FAIL jal_t2_wen got %b exp 0", pc_redirect_wen); end
        @(negedge clk); id_ex_valid = 1'b1; ex_pc_pc_wen = 1'b1; ex_pc_pc_data = 32'h0000_0200; #1;
        checks++; if (ctl !== FLUSH2) begin errors++; $display("FAIL jal_again_flush got %b exp %b", ctl, FLUSH2); end
        @(negedge clk); idle(); #1;
        checks++; if (pc_redirect_data !== 32'h200 || pc_redirect_wen !== 1'b1) begin errors++; $display("FAIL jal_again_data got %h/%b exp 200/1", pc_redirect_data, pc_redirect_wen); end
        @(negedge clk); #1;
        checks++; if (ctl !== 7'b0) begin errors++; $display("FAIL jal_again_end got %b exp 0", ctl); end
        checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL jal_cnt got %0d exp %0d", stall_cnt, exp_cnt); end
    endtask

    task automatic test_load_use();
        @(negedge clk); idle(); set_load_use(5'd5, 5'd5, 5'd1); #1;
        checks++; if (ctl !== LUSE) begin errors++; $display("FAIL lu_rs1 got %b exp %b", ctl, LUSE); end
        checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL lu_cnt0 got %0d exp %0d", stall_cnt, exp_cnt); end
        exp_cnt++;
        @(negedge clk); idle(); #1;
        checks++; if (ctl !== 7'b0) begin errors++; $display("FAIL lu_release got %b exp 0", ctl); end
        checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL lu_cnt1 got %0d exp %0d", stall_cnt, exp_cnt); end
        @(negedge clk); set_load_use(5'd7, 5'd3, 5'd7); #1;
        checks++; if (ctl !== LUSE) begin errors++; $display("FAIL lu_rs2 got %b exp %b", ctl, LUSE); end
        exp_cnt++;
        @(negedge clk); id_rs2_ren = 1'b0; #1;
        checks++; if (ctl !== 7'b0) begin errors++; $display("FAIL lu_noren got %b exp 0", ctl); end
        @(negedge clk); set_load_use(5'd0, 5'd0, 5'd0); #1;
        checks++; if (ctl !== 7'b0) begin errors++; $display("FAIL lu_x0 got %b exp 0", ctl); end
        @(negedge clk); idle(); #1;
        checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL lu_cnt2 got %0d exp %0d", stall_cnt, exp_cnt); end
    endtask

    task automatic test_mc_done();
        @(negedge clk); idle(); id_ex_valid = 1'b1; id_ex_is_mc = 1'b1; #1;
        checks++; if (ctl !== (MCST | C_MS)) begin errors++; $display("FAIL mc_start got %b exp %b", ctl, MCST | C_MS); end
        for (int i = 1; i < 5; i++) begin
            @(negedge clk); #1;
            checks++; if (ctl !== MCST) begin errors++; $display("FAIL mc_wait%0d got %b exp %b", i, ctl, MCST); end
        end
        @(negedge clk); mc_done = 1'b1; #1;
        checks++; if (ctl !== 7'b0) begin errors++; $display("FAIL mc_done_release got %b exp 0", ctl); end
        exp_cnt += 5;
        @(negedge clk); idle(); mc_done = 1'b1; #1;
        checks++; if (ctl !== 7'b0) begin errors++; $display("FAIL mc_done_in_run got %b exp 0", ctl); end
        checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL mc_cnt got %0d exp %0d", stall_cnt, exp_cnt); end
    endtask

    task automatic test_mc_timeout();
        @(negedge clk); idle(); id_ex_valid = 1'b1; id_ex_is_mc = 1'b1; #1;
        checks++; if (ctl !== (MCST | C_MS)) begin errors++; $display("FAIL to_start got %b exp %b", ctl, MCST | C_MS); end
        for (int i = 1; i < MCT; i++) begin
            @(negedge clk); #1;
            checks++; if (ctl !== MCST) begin errors++; $display("FAIL to_wait%0d got %b exp %b", i, ctl, MCST); end
        end
        @(negedge clk); #1;
        checks++; if (ctl !== (C_MT | C_IDF)) begin errors++; $display("FAIL to_expire got %b exp %b", ctl, C_MT | C_IDF); end
        exp_cnt += MCT;
        @(negedge clk); idle(); #1;
        checks++; if (ctl !== 7'b0) begin errors++; $display("FAIL to_after got %b exp 0", ctl); end
        checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL to_cnt got %0d exp %0d", stall_cnt, exp_cnt); end
        @(negedge clk); id_ex_valid = 1'b1; id_ex_is_mc = 1'b1; #1;
        checks++; if (ctl !== (MCST | C_MS)) begin errors++; $display("FAIL to_rerun got %b exp %b", ctl, MCST | C_MS); end
        exp_cnt++;
        @(negedge clk); idle(); mc_done = 1'b1; #1;
        @(negedge clk); idle(); #1;
        checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL to_cnt2 got %0d exp %0d", stall_cnt, exp_cnt); end
    endtask

    task automatic test_conflict_reset();
        @(negedge clk); idle(); set_load_use(5'd9, 5'd9, 5'd9); id_ex_is_mc = 1'b1;
        ex_pc_pc_wen = 1'b1; ex_pc_pc_data = 32'h0000_0300; #1;
        checks++; if (ctl !== FLUSH2) begin errors++; $display("FAIL cf_t got %b exp %b", ctl, FLUSH2); end
        @(negedge clk); idle(); #1;
        checks++; if (ctl !== FLUSH2 || pc_redirect_wen !== 1'b1 || pc_redirect_data !== 32'h300) begin
            errors++; $display("FAIL cf_t1 got %b/%b/%h exp %b/1/300", ctl, pc_redirect_wen, pc_redirect_data, FLUSH2); end
        @(negedge clk); #1;
        checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL cf_cnt got %0d exp %0d", stall_cnt, exp_cnt); end
        @(negedge clk); id_ex_valid = 1'b1; ex_pc_pc_wen = 1'b1; ex_pc_pc_data = 32'h0000_0400; #1;
        @(negedge clk); idle(); rst_n = 1'b0; #1;
        @(negedge clk); rst_n = 1'b1; #1;
        checks++; if (ctl !== 7'b0 || pc_redirect_wen !== 1'b0 || pc_redirect_data !== 32'h0 || stall_cnt !== '0) begin
            errors++; $display("FAIL rst_mid_redirect got %b/%b/%h/%0d exp all 0", ctl, pc_redirect_wen, pc_redirect_data, stall_cnt); end
        exp_cnt = 0;
        @(negedge clk); set_load_use(5'd4, 5'd4, 5'd0); #1;
        checks++; if (ctl !== LUSE) begin errors++; $display("FAIL rst_back_in_run got %b exp %b", ctl, LUSE); end
        @(negedge clk); idle(); #1;
    endtask

    task automatic test_random();
        int          rdir_left = 0;
        int          lu_left   = 0;
        int          mc_age    = 0;
        bit          mc_act    = 0;
        bit          take_rd;
        bit          hz;
        logic        m_wen     = 1'b0;
        logic [31:0] m_data    = '0;
        logic [31:0] m_cnt     = '0;
        logic [6:0]  e;
        @(negedge clk); idle(); rst_n = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst_n         = ($urandom_range(0, 299) != 0);
            id_ex_valid   = ($urandom_range(0, 3) != 0);
            ex_pc_pc_wen  = ($urandom_range(0, 9) == 0);
            ex_pc_pc_data = $urandom;
            id_rs1_addr   = 5'($urandom_range(0, 3));
            id_rs1_ren    = 1'($urandom_range(0, 1));
            id_rs2_addr   = 5'($urandom_range(0, 3));
            id_rs2_ren    = 1'($urandom_range(0, 1));
            id_ex_rd_addr = 5'($urandom_range(0, 3));
            id_ex_rd_wen  = 1'($urandom_range(0, 1));
            id_ex_is_load = 1'($urandom_range(0, 1));
            id_ex_is_mc   = ($urandom_range(0, 11) == 0);
            mc_done       = ($urandom_range(0, 5) == 0);
            #1;
            e = '0;
            take_rd = 0;
            hz = id_ex_valid && id_ex_is_load && id_ex_rd_wen && (id_ex_rd_addr != 0) &&
                 ((id_rs1_ren && id_rs1_addr == id_ex_rd_addr) || (id_rs2_ren && id_rs2_addr == id_ex_rd_addr));
            if (rst_n) begin
                if (rdir_left > 0) begin
                    e = FLUSH2; rdir_left--;
                end else if (lu_left > 0) begin
                    e = LUSE; lu_left--;
                end else if (mc_act) begin
                    mc_age++;
                    if (mc_done) mc_act = 0;
                    else if (mc_age == MCT) begin e = C_MT | C_IDF; mc_act = 0; end
                    else e = MCST;
                end else if (id_ex_valid && ex_pc_pc_wen) begin
                    e = FLUSH2; rdir_left = FLUSH; take_rd = 1;
                end else if (id_ex_valid && id_ex_is_mc) begin
                    e = MCST | C_MS; mc_act = 1; mc_age = 0;
                end else if (hz) begin
                    e = LUSE; lu_left = LU - 1;
                end
            end
            checks++; if (ctl !== e) begin errors++; $display("FAIL rnd_ctl cyc %0d got %b exp %b", n, ctl, e); end
            checks++; if (pc_redirect_wen !== m_wen) begin errors++; $display("FAIL rnd_wen cyc %0d got %b exp %b", n, pc_redirect_wen, m_wen); end
            checks++; if (pc_redirect_data !== m_data) begin errors++; $display("FAIL rnd_data cyc %0d got %h exp %h", n, pc_redirect_data, m_data); end
            checks++; if (stall_cnt !== m_cnt) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d exp %0d", n, stall_cnt, m_cnt); end
            if (!rst_n) begin
                rdir_left = 0; lu_left = 0; mc_act = 0; mc_age = 0;
                m_wen = 1'b0; m_data = '0; m_cnt = '0;
            end else begin
                m_wen = take_rd;
                if (take_rd) m_data = ex_pc_pc_data;
                if (e[6]) m_cnt = m_cnt + 1;
            end
        end
        @(negedge clk); idle(); rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_jal();
        test_load_use();
        test_mc_done();
        test_mc_timeout();
        test_conflict_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
